// File: rtl/zxuno_regport.sv
// zxuno_regport: Z80 bus front end for the ZX-UNO extended register file.
//
// Decodes the register-select port (ADDR_PORT, FC3Bh) and the register-data
// port (DATA_PORT, FD3Bh) with a full 16-bit compare. It holds the selected
// register number and gives every downstream register block a one-cycle
// write strobe, a held read strobe, a read-end pulse and the write data. It
// also returns the byte the CPU reads back.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   a                   CPU address bus
//   iorq_n, rd_n, wr_n  CPU bus controls, active-low
//   m1_n                CPU M1, active-low; with IORQ it marks an interrupt ack
//   cpu_din             CPU write data
//   cpu_dout, cpu_oe_n  CPU read data and its bus-drive enable (low = drive)
//   reg_din, reg_oe_n   wired read data and claim from downstream blocks
//   zxuno_addr          selected register number
//   zxuno_data          write data, valid while zxuno_regwr=1
//   zxuno_regwr         one-cycle write strobe
//   zxuno_regrd         read strobe, held for the whole FD3Bh read
//   zxuno_rdend         one-cycle pulse after an FD3Bh read ends
module zxuno_regport #(
  parameter logic [15:0] ADDR_PORT = 16'hFC3B,
  parameter logic [15:0] DATA_PORT = 16'hFD3B
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] a,
  input  logic        iorq_n,
  input  logic        rd_n,
  input  logic        wr_n,
  input  logic        m1_n,
  input  logic [7:0]  cpu_din,
  output logic [7:0]  cpu_dout,
  output logic        cpu_oe_n,
  input  logic [7:0]  reg_din,
  input  logic        reg_oe_n,
  output logic [7:0]  zxuno_addr,
  output logic [7:0]  zxuno_data,
  output logic        zxuno_regwr,
  output logic        zxuno_regrd,
  output logic        zxuno_rdend
);

  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StWrHold  = 2'd1;
  localparam logic [1:0] StRdHold  = 2'd2;
  localparam logic [1:0] StWaitEnd = 2'd3;

  logic [1:0] r_state;
  logic [7:0] r_addr;
  logic [7:0] r_data;
  logic       r_regwr;
  logic       r_rdend;
  logic       r_rd_data;   // current read access targets DATA_PORT
  logic       r_fresh;     // first clock after reset release

  logic [1:0] w_state_d;
  logic [7:0] w_addr_d;
  logic [7:0] w_data_d;
  logic       w_regwr_d;
  logic       w_rdend_d;
  logic       w_rd_data_d;

  logic w_io_wr;
  logic w_io_rd;
  logic w_addr_hit;
  logic w_data_hit;
  logic w_port_hit;

  // RD and WR both low, or an interrupt acknowledge, is not an access.
  assign w_io_wr    = !iorq_n && !wr_n && rd_n && m1_n;
  assign w_io_rd    = !iorq_n && !rd_n && wr_n && m1_n;
  assign w_addr_hit = (a == ADDR_PORT);
  assign w_data_hit = (a == DATA_PORT);
  assign w_port_hit = w_addr_hit || w_data_hit;

  always_comb begin
    w_state_d   = r_state;
    w_addr_d    = r_addr;
    w_data_d    = r_data;
    w_regwr_d   = 1'b0;
    w_rdend_d   = 1'b0;
    w_rd_data_d = r_rd_data;
    case (r_state)
      StIdle: begin
        if (r_fresh && (w_io_rd || w_io_wr)) begin
          // Access already under way when reset let go: let it finish silently.
          w_state_d = StWaitEnd;
        end else if (w_io_wr && w_port_hit) begin
          w_state_d = StWrHold;
          if (w_addr_hit) begin
            w_addr_d = cpu_din;
          end else begin
            w_data_d  = cpu_din;
            w_regwr_d = 1'b1;
          end
        end else if (w_io_rd && w_port_hit) begin
          w_state_d   = StRdHold;
          w_rd_data_d = w_data_hit;
        end
      end
      StWrHold: begin
        if (!w_io_wr) w_state_d = StIdle;
      end
      StRdHold: begin
        if (!w_io_rd) begin
          w_state_d = StIdle;
          w_rdend_d = r_rd_data;
        end
      end
      StWaitEnd: begin
        if (!w_io_rd && !w_io_wr) w_state_d = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= StIdle;
      r_addr    <= 8'h00;
      r_data    <= 8'h00;
      r_regwr   <= 1'b0;
      r_rdend   <= 1'b0;
      r_rd_data <= 1'b0;
      r_fresh   <= 1'b1;
    end else begin
      r_state   <= w_state_d;
      r_addr    <= w_addr_d;
      r_data    <= w_data_d;
      r_regwr   <= w_regwr_d;
      r_rdend   <= w_rdend_d;
      r_rd_data <= w_rd_data_d;
      r_fresh   <= 1'b0;
    end
  end

  // Read path is purely combinational so the CPU sees data in the same cycle.
  always_comb begin
    cpu_oe_n = 1'b1;
    cpu_dout = 8'hFF;
    if (w_io_rd && w_addr_hit) begin
      cpu_oe_n = 1'b0;
      cpu_dout = r_addr;
    end else if (w_io_rd && w_data_hit) begin
      cpu_oe_n = 1'b0;
      cpu_dout = reg_oe_n ? 8'hFF : reg_din;
    end
  end

  assign zxuno_regrd = w_io_rd && w_data_hit;
  assign zxuno_addr  = r_addr;
  assign zxuno_data  = r_data;
  assign zxuno_regwr = r_regwr;
  assign zxuno_rdend = r_rdend;

endmodule

// File: tb/tb_zxuno_regport.sv
module tb_zxuno_regport;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] a = 16'h0000;
  logic        iorq_n = 1'b1;
  logic        rd_n = 1'b1;
  logic        wr_n = 1'b1;
  logic        m1_n = 1'b1;
  logic [7:0]  cpu_din = 8'h00;
  logic [7:0]  cpu_dout;
  logic        cpu_oe_n;
  logic [7:0]  reg_din = 8'h00;
  logic        reg_oe_n = 1'b1;
  logic [7:0]  zxuno_addr;
  logic [7:0]  zxuno_data;
  logic        zxuno_regwr;
  logic        zxuno_regrd;
  logic        zxuno_rdend;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  zxuno_regport dut (
    .clk        (clk),
    .rst        (rst),
    .a          (a),
    .iorq_n     (iorq_n),
    .rd_n       (rd_n),
    .wr_n       (wr_n),
    .m1_n       (m1_n),
    .cpu_din    (cpu_din),
    .cpu_dout   (cpu_dout),
    .cpu_oe_n   (cpu_oe_n),
    .reg_din    (reg_din),
    .reg_oe_n   (reg_oe_n),
    .zxuno_addr (zxuno_addr),
    .zxuno_data (zxuno_data),
    .zxuno_regwr(zxuno_regwr),
    .zxuno_regrd(zxuno_regrd),
    .zxuno_rdend(zxuno_rdend)
  );

  typedef struct {
    logic [15:0] a;
    logic        iorq_n, rd_n, wr_n, m1_n;
    logic [7:0]  din, rdin;
    logic        roe_n;
    logic        e_oe_n;
    logic [7:0]  e_dout;
    logic        e_regrd, e_regwr, e_rdend;
    logic [7:0]  e_addr, e_data;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic [15:0] ia, input logic iq, ir, iw, im,
                     input logic [7:0] idin, irdin, input logic iroe,
                     input logic eoe, input logic [7:0] edout,
                     input logic erd, ewr, erde, input logic [7:0] eaddr, edata);
    vec_t v;
    v.a = ia; v.iorq_n = iq; v.rd_n = ir; v.wr_n = iw; v.m1_n = im;
    v.din = idin; v.rdin = irdin; v.roe_n = iroe;
    v.e_oe_n = eoe; v.e_dout = edout; v.e_regrd = erd; v.e_regwr = ewr;
    v.e_rdend = erde; v.e_addr = eaddr; v.e_data = edata;
    tbl.push_back(v);
  endtask

  task automatic idl(input logic [7:0] eaddr, edata, input logic erde);
    add(16'h0000, 1, 1, 1, 1, 8'h00, 8'h00, 1, 1, 8'hFF, 0, 0, erde, eaddr, edata);
  endtask

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %02h want %02h", nm, act, exp);
    end
  endtask

  // One bus cycle: drive just after the edge, leave the caller at mid-cycle.
  task automatic cyc(input logic [15:0] ia, input logic iq, ir, iw, im,
                     input logic [7:0] idin);
    @(posedge clk);
    #1;
    a = ia; iorq_n = iq; rd_n = ir; wr_n = iw; m1_n = im; cpu_din = idin;
    #4;
  endtask

  int pulses;
  logic [7:0] caps [2];

  initial begin
    // Reset values; read strobes follow the bus even in reset.
    cyc(16'h0000, 1, 1, 1, 1, 8'h00);
    chk("rst_addr", zxuno_addr, 8'h00);
    chk("rst_data", zxuno_data, 8'h00);
    chk("rst_regwr", {7'd0, zxuno_regwr}, 8'h00);
    chk("rst_oe_n", {7'd0, cpu_oe_n}, 8'h01);
    cyc(16'hFD3B, 0, 0, 1, 1, 8'h00);
    chk("rst_regrd_comb", {7'd0, zxuno_regrd}, 8'h01);
    chk("rst_oe_comb", {7'd0, cpu_oe_n}, 8'h00);
    cyc(16'h0000, 1, 1, 1, 1, 8'h00);
    @(posedge clk);
    #1 rst = 1'b0;
    cyc(16'h0000, 1, 1, 1, 1, 8'h00);

    // Table-driven main sequence, one row per clock.
    add(16'hFC3B, 0, 0, 1, 1, 8'h00, 8'h00, 1, 0, 8'h00, 0, 0, 0, 8'h00, 8'h00);
    add(16'hFC3B, 0, 0, 1, 1, 8'h00, 8'h00, 1, 0, 8'h00, 0, 0, 0, 8'h00, 8'h00);
    idl(8'h00, 8'h00, 0);
    idl(8'h00, 8'h00, 0);
    add(16'hFC3B, 0, 1, 0, 1, 8'h0E, 8'h00, 1, 1, 8'hFF, 0, 0, 0, 8'h00, 8'h00);
    for (int k = 0; k < 3; k++)
      add(16'hFC3B, 0, 1, 0, 1, 8'h0E, 8'h00, 1, 1, 8'hFF, 0, 0, 0, 8'h0E, 8'h00);
    idl(8'h0E, 8'h00, 0);
    add(16'hFD3B, 0, 1, 0, 1, 8'h5A, 8'h00, 1, 1, 8'hFF, 0, 0, 0, 8'h0E, 8'h00);
    add(16'hFD3B, 0, 1, 0, 1, 8'h5A, 8'h00, 1, 1, 8'hFF, 0, 1, 0, 8'h0E, 8'h5A);
    add(16'hFD3B, 0, 1, 0, 1, 8'h5A, 8'h00, 1, 1, 8'hFF, 0, 0, 0, 8'h0E, 8'h5A);
    add(16'hFD3B, 0, 1, 0, 1, 8'h5A, 8'h00, 1, 1, 8'hFF, 0, 0, 0, 8'h0E, 8'h5A);
    idl(8'h0E, 8'h5A, 0);
    for (int k = 0; k < 3; k++)
      add(16'hFD3B, 0, 0, 1, 1, 8'h00, 8'h3C, 0, 0, 8'h3C, 1, 0, 0, 8'h0E, 8'h5A);
    idl(8'h0E, 8'h5A, 0);
    idl(8'h0E, 8'h5A, 1);
    idl(8'h0E, 8'h5A, 0);
    for (int k = 0; k < 2; k++)
      add(16'hFD3B, 0, 0, 1, 1, 8'h00, 8'h3C, 1, 0, 8'hFF, 1, 0, 0, 8'h0E, 8'h5A);
    idl(8'h0E, 8'h5A, 0);
    idl(8'h0E, 8'h5A, 1);
    idl(8'h0E, 8'h5A, 0);
    for (int k = 0; k < 2; k++)  // neighbouring port
      add(16'hFD3C, 0, 1, 0, 1, 8'h99, 8'h00, 1, 1, 8'hFF, 0, 0, 0, 8'h0E, 8'h5A);
    idl(8'h0E, 8'h5A, 0);
    idl(8'h0E, 8'h5A, 0);
    for (int k = 0; k < 2; k++)  // M1 low: interrupt acknowledge
      add(16'hFD3B, 0, 1, 0, 0, 8'h99, 8'h00, 1, 1, 8'hFF, 0, 0, 0, 8'h0E, 8'h5A);
    idl(8'h0E, 8'h5A, 0);
    for (int k = 0; k < 2; k++)  // RD and WR both low
      add(16'hFC3B, 0, 0, 0, 1, 8'h99, 8'h00, 1, 1, 8'hFF, 0, 0, 0, 8'h0E, 8'h5A);
    idl(8'h0E, 8'h5A, 0);
    add(16'hFD3B, 0, 0, 1, 0, 8'h00, 8'h3C, 0, 1, 8'hFF, 0, 0, 0, 8'h0E, 8'h5A);
    idl(8'h0E, 8'h5A, 0);
    idl(8'h0E, 8'h5A, 0);
    add(16'hFC3B, 0, 0, 1, 1, 8'h00, 8'h3C, 0, 0, 8'h0E, 0, 0, 0, 8'h0E, 8'h5A);
    idl(8'h0E, 8'h5A, 0);
    idl(8'h0E, 8'h5A, 0);

    foreach (tbl[i]) begin
      @(posedge clk);
      #1;
      a = tbl[i].a; iorq_n = tbl[i].iorq_n; rd_n = tbl[i].rd_n; wr_n = tbl[i].wr_n;
      m1_n = tbl[i].m1_n; cpu_din = tbl[i].din; reg_din = tbl[i].rdin;
      reg_oe_n = tbl[i].roe_n;
      #4;
      chk($sformatf("v%0d_oe_n", i), {7'd0, cpu_oe_n}, {7'd0, tbl[i].e_oe_n});
      chk($sformatf("v%0d_dout", i), cpu_dout, tbl[i].e_dout);
      chk($sformatf("v%0d_regrd", i), {7'd0, zxuno_regrd}, {7'd0, tbl[i].e_regrd});
      chk($sformatf("v%0d_regwr", i), {7'd0, zxuno_regwr}, {7'd0, tbl[i].e_regwr});
      chk($sformatf("v%0d_rdend", i), {7'd0, zxuno_rdend}, {7'd0, tbl[i].e_rdend});
      chk($sformatf("v%0d_addr", i), zxuno_addr, tbl[i].e_addr);
      chk($sformatf("v%0d_data", i), zxuno_data, tbl[i].e_data);
    end
    reg_oe_n = 1'b1;

    // Reset lands in the second cycle of a data write, released mid-access.
    cyc(16'hFD3B, 0, 1, 0, 1, 8'h22);
    chk("rw_c0_regwr", {7'd0, zxuno_regwr}, 8'h00);
    @(posedge clk);
    #1 rst = 1'b1;
    #4;
    chk("rw_c1_regwr", {7'd0, zxuno_regwr}, 8'h00);
    chk("rw_c1_data", zxuno_data, 8'h00);
    chk("rw_c1_addr", zxuno_addr, 8'h00);
    cyc(16'hFD3B, 0, 1, 0, 1, 8'h22);
    @(posedge clk);
    #1 rst = 1'b0;
    #4;
    chk("rw_rel_regwr", {7'd0, zxuno_regwr}, 8'h00);
    for (int k = 0; k < 4; k++) begin
      if (k < 2) cyc(16'hFD3B, 0, 1, 0, 1, 8'h22);
      else cyc(16'h0000, 1, 1, 1, 1, 8'h00);
      chk($sformatf("rw_tail%0d_regwr", k), {7'd0, zxuno_regwr}, 8'h00);
    end
    chk("rw_tail_data", zxuno_data, 8'h00);
    pulses = 0;
    for (int k = 0; k < 6; k++) begin
      if (k < 4) cyc(16'hFD3B, 0, 1, 0, 1, 8'h11);
      else cyc(16'h0000, 1, 1, 1, 1, 8'h00);
      if (zxuno_regwr) begin
        pulses++;
        chk("rw_next_data", zxuno_data, 8'h11);
      end
    end
    chk("rw_next_pulses", pulses[7:0], 8'd1);

    // Long write, one idle clock, second write.
    pulses = 0;
    caps[0] = 8'h00;
    caps[1] = 8'h00;
    for (int k = 0; k < 15; k++) begin
      if (k < 8) cyc(16'hFD3B, 0, 1, 0, 1, 8'h77);
      else if (k == 8) cyc(16'h0000, 1, 1, 1, 1, 8'h00);
      else if (k < 13) cyc(16'hFD3B, 0, 1, 0, 1, 8'h88);
      else cyc(16'h0000, 1, 1, 1, 1, 8'h00);
      if (zxuno_regwr) begin
        if (pulses < 2) caps[pulses] = zxuno_data;
        pulses++;
      end
    end
    chk("b2b_pulses", pulses[7:0], 8'd2);
    chk("b2b_first", caps[0], 8'h77);
    chk("b2b_second", caps[1], 8'h88);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
